// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle between the calculator controller and serial_subtractor.
// master = controller side, slave = subtractor side.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's complement subtractor (diff = a - b), LSB first, one borrow cell and a borrow flop.
// Optional macro SUB_SATURATE_EN clamps diff to the signed range on overflow.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_subtractor_if.slave    bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

`ifdef SUB_SATURATE_EN
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             bw_q, bw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic             a_bit, b_bit, d_bit, bw_next, ovf_raw;
  logic [WIDTH-1:0] raw_diff;

  // Difference bits enter the minuend register from the MSB side as its bits are consumed,
  // so after WIDTH shifts that register holds the full raw result.
  always_comb begin
    a_bit    = a_q[0];
    b_bit    = b_q[0];
    d_bit    = a_bit ^ b_bit ^ bw_q;
    bw_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bw_q);
    ovf_raw  = (a_bit ^ b_bit) & (d_bit ^ a_bit);
    raw_diff = {d_bit, a_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    bw_d     = bw_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SHIFT;
          a_d     = bus.a;
          b_d     = bus.b;
          bw_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        a_d   = raw_diff;
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        bw_d  = bw_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d  = ST_DONE;
          cnt_d    = '0;
          borrow_d = bw_next;
          ovf_d    = ovf_raw;
`ifdef SUB_SATURATE_EN
          if (ovf_raw)
            diff_d = a_bit ? MIN_NEG : MAX_POS;
          else
            diff_d = raw_diff;
`else
          diff_d = raw_diff;
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      bw_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      bw_q     <= bw_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.diff     = diff_q;
  assign bus.borrow   = borrow_q;
  assign bus.overflow = ovf_q;

endmodule
